// File: rtl/framer_pkg.sv
// Shared types and constants for the sensor packet framer.
// Checksum type is chosen at build time by FRAMER_CRC8_EN (see framer_chk_update).
package framer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ID,
        ST_SEQ,
        ST_LEN,
        ST_PAY_REQ,
        ST_PAY_CAP,
        ST_PAY_SEND,
        ST_CHK
    } state_t;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/framer_chk_update.sv
// One-byte checksum step: CRC-8/0x07 (MSB-first) when FRAMER_CRC8_EN is defined,
// otherwise a plain bytewise XOR.
module framer_chk_update (
    input  logic [7:0] chk_in,
    input  logic [7:0] data,
    output logic [7:0] chk_out
);

`ifdef FRAMER_CRC8_EN
    import framer_pkg::*;

    // NOTE: chk_out gets a value before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        chk_out = chk_in ^ data;
        for (int i = 0; i < 8; i++) begin
            chk_out = chk_out[7] ? ((chk_out << 1) ^ CRC8_POLY) : (chk_out << 1);
        end
    end
`else
    assign chk_out = chk_in ^ data;
`endif

endmodule

// File: rtl/sensor_packet_framer.sv
// Pops fixed-length payloads from the sensor FIFO and emits SYNC, ID, SEQ, LEN, payload, CHK frames
// on a valid/ready byte stream. FRAMER_CRC8_EN selects CRC-8 instead of XOR for CHK.
module sensor_packet_framer
    import framer_pkg::*;
#(
    parameter int               DATA_WIDTH  = 8,
    parameter int               FIFO_DEPTH  = 16,
    parameter int               PAYLOAD_LEN = 4,
    parameter logic [7:0]       SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]             fifo_rd_data,
    input  logic                              fifo_empty,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    input  logic [DATA_WIDTH-1:0]             sensor_id,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              busy,
    output logic                              frame_done
);

    localparam int         BW       = $clog2(PAYLOAD_LEN + 1);
    localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN);

    state_t          state, state_n;
    logic [7:0]      id_q, seq_q, chk_q, pay_q;
    logic [7:0]      chk_next;
    logic [BW-1:0]   cnt_q;
    logic            chk_en;

    framer_chk_update u_chk (
        .chk_in  (chk_q),
        .data    (m_data),
        .chk_out (chk_next)
    );

    always_comb begin
        state_n    = state;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        fifo_rd_en = 1'b0;
        frame_done = 1'b0;
        chk_en     = 1'b0;
        case (state)
            ST_IDLE:     if (32'(fifo_count) >= PAYLOAD_LEN) state_n = ST_SYNC;
            ST_SYNC: begin
                m_valid = 1'b1;
                m_data  = SYNC_BYTE;
                if (m_ready) state_n = ST_ID;
            end
            ST_ID: begin
                m_valid = 1'b1;
                m_data  = id_q;
                chk_en  = m_ready;
                if (m_ready) state_n = ST_SEQ;
            end
            ST_SEQ: begin
                m_valid = 1'b1;
                m_data  = seq_q;
                chk_en  = m_ready;
                if (m_ready) state_n = ST_LEN;
            end
            ST_LEN: begin
                m_valid = 1'b1;
                m_data  = LEN_BYTE;
                chk_en  = m_ready;
                if (m_ready) state_n = ST_PAY_REQ;
            end
            // Never pop an empty FIFO; wait here until data shows up.
            ST_PAY_REQ: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_n = ST_PAY_CAP;
            end
            ST_PAY_CAP:  state_n = ST_PAY_SEND;
            ST_PAY_SEND: begin
                m_valid = 1'b1;
                m_data  = pay_q;
                chk_en  = m_ready;
                if (m_ready) state_n = (cnt_q == BW'(PAYLOAD_LEN - 1)) ? ST_CHK : ST_PAY_REQ;
            end
            ST_CHK: begin
                m_valid    = 1'b1;
                m_last     = 1'b1;
                m_data     = chk_q;
                frame_done = m_ready;
                if (m_ready) state_n = ST_IDLE;
            end
            default:     state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            id_q  <= '0;
            seq_q <= '0;
            chk_q <= '0;
            pay_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && state_n == ST_SYNC) begin
                id_q  <= sensor_id;
                chk_q <= '0;
                cnt_q <= '0;
            end
            if (chk_en)                          chk_q <= chk_next;
            if (state == ST_PAY_CAP)             pay_q <= fifo_rd_data;
            if (state == ST_PAY_SEND && m_ready) cnt_q <= cnt_q + 1'b1;
            if (state == ST_CHK && m_ready)      seq_q <= seq_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_sensor_packet_framer.sv
// Self-checking bench for sensor_packet_framer with a small sync-FIFO model upstream.
// Define FRAMER_CRC8_EN for both bench and RTL to check the CRC-8 build.
module tb_sensor_packet_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic [7:0]  sensor_id = 8'h3C;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic        frame_done;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    bit          bp_mode = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    sensor_packet_framer #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .PAYLOAD_LEN(4),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .sensor_id   (sensor_id),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: rd_data valid the cycle after the pop.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    assign fifo_count = cnt;
    assign fifo_empty = (cnt == 5'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0; rp <= '0; cnt <= '0; fifo_rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            if (fifo_rd_en && cnt != 5'd0) begin
                fifo_rd_data <= mem[rp];
                rp           <= rp + 4'd1;
            end
            cnt <= cnt + 5'(wr_en) - 5'(fifo_rd_en && cnt != 5'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor, sampled on the falling edge.
    logic [7:0] rx_data [$];
    bit         rx_last [$];
    int         done_cnt = 0, rd_cnt = 0, stall_err = 0, rd_empty_err = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_data !== prev_data) stall_err++;
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
            end
            if (frame_done) done_cnt++;
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && fifo_empty) rd_empty_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

`ifdef FRAMER_CRC8_EN
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    // Expected CHK: hand-computed XOR constant, or golden CRC over ID, SEQ, LEN, payload.
    function automatic logic [7:0] exp_chk(input logic [7:0] seq, input logic [31:0] pay,
                                           input logic [7:0] xchk);
`ifdef FRAMER_CRC8_EN
        logic [7:0] c = 8'h00;
        c = crc_step(c, 8'h3C);
        c = crc_step(c, seq);
        c = crc_step(c, 8'h04);
        for (int i = 0; i < 4; i++) c = crc_step(c, pay[31-8*i -: 8]);
        return c;
`else
        return xchk;
`endif
    endfunction

    int d0, r0;

    task automatic write_bytes(input logic [31:0] pay);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = pay[31-8*i -: 8];
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) break;
        end
        @(negedge clk); #1;
    endtask

    task automatic check_frame(input logic [7:0] seq, input logic [31:0] pay, input logic [7:0] xchk);
        logic [7:0] e [9];
        logic [8:0] lm = '0;
        e[0] = 8'hA5; e[1] = 8'h3C; e[2] = seq; e[3] = 8'h04;
        for (int i = 0; i < 4; i++) e[4+i] = pay[31-8*i -: 8];
        e[8] = exp_chk(seq, pay, xchk);
        check("rx_len", rx_data.size(), 9);
        if (rx_data.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("seq%0h_byte%0d", seq, i), rx_data[i], e[i]);
                lm[i] = rx_last[i];
            end
        end
        check("m_last_pos", lm, 9'h100);
        check("frame_done_cnt", done_cnt - d0, 1);
        check("rd_pulses", rd_cnt - r0, 4);
    endtask

    task automatic run_frame(input logic [31:0] pay, input bit bp, input bit do_check,
                             input logic [7:0] seq, input logic [7:0] xchk, output bit ok);
        rx_data.delete(); rx_last.delete();
        d0 = done_cnt; r0 = rd_cnt;
        bp_mode = bp;
        write_bytes(pay);
        wait_done();
        bp_mode = 1'b0;
        ok = (done_cnt - d0 == 1);
        if (do_check) check_frame(seq, pay, xchk);
    endtask

    typedef struct {
        logic [31:0] pay;
        logic [7:0]  seq;
        logic [7:0]  xchk;
        bit          bp;
    } vec_t;

    vec_t tbl [5];
    bit   ok;
    int   frames_ok;

    initial begin
        tbl[0] = '{pay: 32'h01020304, seq: 8'h00, xchk: 8'h3C, bp: 1'b0};
        tbl[1] = '{pay: 32'h05060708, seq: 8'h01, xchk: 8'h35, bp: 1'b0};
        tbl[2] = '{pay: 32'h10203040, seq: 8'h02, xchk: 8'h7A, bp: 1'b1};
        tbl[3] = '{pay: 32'hFF00AA55, seq: 8'h03, xchk: 8'h3B, bp: 1'b0};
        tbl[4] = '{pay: 32'h80017E3C, seq: 8'h04, xchk: 8'hFF, bp: 1'b1};

        // Reset state
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_data", m_data, 0);
        check("rst_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_empty_rd", rd_cnt, 0);
        check("idle_empty_valid", m_valid, 0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) run_frame(tbl[v].pay, tbl[v].bp, 1'b1, tbl[v].seq, tbl[v].xchk, ok);

        // Threshold: 3 bytes stay idle, 4th starts the frame one cycle after it lands
        rx_data.delete(); rx_last.delete();
        d0 = done_cnt; r0 = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h11 * 8'(i + 1);
        end
        @(posedge clk); #1 wr_en = 1'b0;
        repeat (5) @(negedge clk);
        check("thr3_busy", busy, 0);
        check("thr3_rd", rd_cnt - r0, 0);
        @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h44;
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        check("thr4_idle_cycle", busy, 0);
        @(negedge clk);
        check("thr4_busy", busy, 1);
        check("thr4_sync", m_data, 8'hA5);
        wait_done();
        check_frame(8'h05, 32'h11223344, 8'h79);

        // Sequence wrap: frames 6..255 unchecked, then SEQ returns to 00
        frames_ok = 0;
        for (int f = 6; f < 256; f++) begin
            run_frame(32'h00000000, 1'b0, 1'b0, 8'(f), 8'h00, ok);
            frames_ok += int'(ok);
        end
        check("wrap_frames", frames_ok, 250);
        run_frame(32'h00000000, 1'b0, 1'b1, 8'h00, 8'h38, ok);

        // Async reset after two payload bytes
        rx_data.delete(); rx_last.delete();
        write_bytes(32'hDEADBEEF);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (rx_data.size() >= 6) break;
        end
        check("mid_seq_byte", (rx_data.size() >= 3) ? rx_data[2] : 8'hXX, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("async_m_valid", m_valid, 0);
        check("async_busy", busy, 0);
        check("async_rd_en", fifo_rd_en, 0);
        check("async_m_data", m_data, 0);
        check("async_m_last", m_last, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_frame(32'h0A0B0C0D, 1'b0, 1'b1, 8'h00, 8'h38, ok);

        check("stall_stable", stall_err, 0);
        check("rd_while_empty", rd_empty_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
